// File: rtl/psram_qspi_pkg.sv
//-----------------------------------------------------------------------------
// psram_qspi_pkg
// Shared definitions for the quad-SPI PSRAM responder: the command opcodes of
// an LY68L6400-class device, the responder state encoding and the wrap page
// geometry used for burst address increment.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
package psram_qspi_pkg;

    // Command opcodes
    localparam logic [7:0] CMD_RSTEN   = 8'h66;
    localparam logic [7:0] CMD_RST     = 8'h99;
    localparam logic [7:0] CMD_SPI2QPI = 8'h35;
    localparam logic [7:0] CMD_QPI2SPI = 8'hF5;
    localparam logic [7:0] CMD_READ    = 8'hEB;
    localparam logic [7:0] CMD_WRITE   = 8'h38;

    // Bursts wrap inside a 1 KiB page
    localparam int PAGE_SIZE = 1024;
    localparam int PAGE_BITS = $clog2(PAGE_SIZE);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SPI_CMD  = 3'd1,
        ST_QPI_CMD  = 3'd2,
        ST_QPI_ADDR = 3'd3,
        ST_WR_DATA  = 3'd4,
        ST_RD_WAIT  = 3'd5,
        ST_RD_DATA  = 3'd6,
        ST_IGNORE   = 3'd7
    } psram_state_e;

endpackage

// File: rtl/psram_resp_ram.sv
//-----------------------------------------------------------------------------
// psram_resp_ram
// Single-port byte RAM backing the PSRAM responder. Synchronous read with one
// cycle of latency; write has priority when both enables are high. Contents
// are not reset.
//
// Ports
//   i_clk    : clock
//   i_we     : write enable (writes i_wdata to i_addr)
//   i_re     : read enable (o_rdata <= mem[i_addr] next edge)
//   i_addr   : byte address
//   i_wdata  : write byte
//   o_rdata  : read byte, registered
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
module psram_resp_ram #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [7:0]            i_wdata,
    output logic [7:0]            o_rdata
);

    logic [7:0] r_mem [2**ADDR_WIDTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end else if (i_re) begin
            o_rdata <= r_mem[i_addr];
        end
    end

endmodule

// File: rtl/psram_qspi_responder.sv
//-----------------------------------------------------------------------------
// psram_qspi_responder
// Quad-SPI PSRAM target model (LY68L6400-class) for loopback / FPGA self-test
// builds. Handles the SPI init sequence (66h, 99h, 35h), QPI EBh reads and
// 38h writes, and F5h return to SPI, backed by an internal byte RAM.
//
// Parameters
//   ADDR_WIDTH : stored byte-address bits (>= 10, <= 24); upper bits alias
//   READ_WAIT  : wait cycles between last address nibble and first data
//                nibble (>= 1)
//
// Ports
//   mem_clk   : PSRAM clock; sampled on posedge, controller drives on negedge
//   rst_n     : asynchronous reset, active low
//   mem_ce    : chip enable, active low
//   mem_sio   : quad bus; driven only in read-data cycles
//   qpi_mode  : 1 while in QPI mode
//   wr_strobe : one-cycle pulse per byte committed to RAM
//   rd_strobe : one-cycle pulse per byte fetched from RAM
//   proto_err : sticky protocol error flag
//
// Configuration macro
//   PSRAM_QSPI_RESPONDER_PROTOCOL_CHECK_EN : enables protocol checking;
//   when undefined proto_err is tied low.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
module psram_qspi_responder
    import psram_qspi_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int READ_WAIT  = 6
) (
    input  logic       mem_clk,
    input  logic       rst_n,
    input  logic       mem_ce,
    inout  wire  [3:0] mem_sio,
    output logic       qpi_mode,
    output logic       wr_strobe,
    output logic       rd_strobe,
    output logic       proto_err
);

    // k at which the first read byte is fetched from RAM
    localparam logic [15:0] FETCH_K = 16'(7 + READ_WAIT);

    psram_state_e          r_state;
    logic [15:0]           r_cnt;      // k of the current posedge (saturating)
    logic [7:0]            r_sh;       // command shift register
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_is_rd;
    logic                  r_qpi;
    logic                  r_armed;
    logic                  r_half;     // write high nibble pending
    logic [3:0]            r_hi;
    logic                  r_we;
    logic [7:0]            r_wdata;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic                  r_wr_stb;
    logic                  r_rd_stb;
    logic                  r_oe;
    logic [3:0]            r_sio_out;
    logic [3:0]            r_lo;       // low nibble held while next byte prefetches
    logic                  r_phase;    // 0: high nibble next, 1: low nibble next

    logic [7:0]            w_cmd;
    logic                  w_cmd_done;
    logic                  w_re;
    logic [ADDR_WIDTH-1:0] w_ram_addr;
    logic [7:0]            w_rdata;

    // Increment within the 1 KiB page; page-select bits are held
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] n;
        n = a;
        n[PAGE_BITS-1:0] = a[PAGE_BITS-1:0] + PAGE_BITS'(1);
        return n;
    endfunction

    // The final command bit/nibble is consumed straight off the bus
    always_comb begin
        w_cmd      = (r_state == ST_SPI_CMD) ? {r_sh[6:0], mem_sio[0]} : {r_sh[3:0], mem_sio};
        w_cmd_done = !mem_ce && (((r_state == ST_SPI_CMD) && (r_cnt == 16'd7)) ||
                                 (r_state == ST_QPI_CMD));
        w_re       = !mem_ce && (((r_state == ST_RD_WAIT) && (r_cnt == FETCH_K)) ||
                                 ((r_state == ST_RD_DATA) && !r_phase));
        w_ram_addr = r_we ? r_waddr : r_addr;
    end

    psram_resp_ram #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .i_clk   (mem_clk),
        .i_we    (r_we),
        .i_re    (w_re),
        .i_addr  (w_ram_addr),
        .i_wdata (r_wdata),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_sh      <= '0;
            r_addr    <= '0;
            r_is_rd   <= 1'b0;
            r_qpi     <= 1'b0;
            r_armed   <= 1'b0;
            r_half    <= 1'b0;
            r_hi      <= '0;
            r_we      <= 1'b0;
            r_wdata   <= '0;
            r_waddr   <= '0;
            r_wr_stb  <= 1'b0;
            r_rd_stb  <= 1'b0;
            r_oe      <= 1'b0;
            r_sio_out <= '0;
            r_lo      <= '0;
            r_phase   <= 1'b0;
        end else begin
            r_we     <= 1'b0;
            r_wr_stb <= 1'b0;
            r_rd_stb <= w_re;
            if (mem_ce) begin
                // Abort: a pending half byte is simply dropped
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_half  <= 1'b0;
                r_oe    <= 1'b0;
                r_phase <= 1'b0;
            end else begin
                if (r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
                case (r_state)
                    ST_IDLE: begin
                        r_sh    <= r_qpi ? {4'h0, mem_sio} : {7'h0, mem_sio[0]};
                        r_state <= r_qpi ? ST_QPI_CMD : ST_SPI_CMD;
                    end
                    ST_SPI_CMD: begin
                        r_sh <= {r_sh[6:0], mem_sio[0]};
                        if (r_cnt == 16'd7) r_state <= ST_IGNORE;
                    end
                    ST_QPI_CMD: begin
                        r_state <= ST_IGNORE;
                    end
                    ST_QPI_ADDR: begin
                        // Only the low ADDR_WIDTH bits of the 24-bit address survive
                        r_addr <= {r_addr[ADDR_WIDTH-5:0], mem_sio};
                        if (r_cnt == 16'd7) r_state <= r_is_rd ? ST_RD_WAIT : ST_WR_DATA;
                    end
                    ST_WR_DATA: begin
                        if (!r_half) begin
                            r_hi   <= mem_sio;
                            r_half <= 1'b1;
                        end else begin
                            r_we     <= 1'b1;
                            r_wdata  <= {r_hi, mem_sio};
                            r_waddr  <= r_addr;
                            r_addr   <= next_addr(r_addr);
                            r_wr_stb <= 1'b1;
                            r_half   <= 1'b0;
                        end
                    end
                    ST_RD_WAIT: begin
                        if (r_cnt == FETCH_K) begin
                            r_addr  <= next_addr(r_addr);
                            r_phase <= 1'b0;
                            r_state <= ST_RD_DATA;
                        end
                    end
                    ST_RD_DATA: begin
                        r_oe <= 1'b1;
                        if (!r_phase) begin
                            // Present high nibble, park low nibble, prefetch next byte
                            r_sio_out <= w_rdata[7:4];
                            r_lo      <= w_rdata[3:0];
                            r_addr    <= next_addr(r_addr);
                            r_phase   <= 1'b1;
                        end else begin
                            r_sio_out <= r_lo;
                            r_phase   <= 1'b0;
                        end
                    end
                    default: ;
                endcase

                if (w_cmd_done) begin
                    r_armed <= (w_cmd == CMD_RSTEN);
                    case (w_cmd)
                        CMD_RST:     if (r_armed) r_qpi <= 1'b0;
                        CMD_SPI2QPI: if (!r_qpi)  r_qpi <= 1'b1;
                        CMD_QPI2SPI: if (r_qpi)   r_qpi <= 1'b0;
                        CMD_READ, CMD_WRITE: begin
                            if (r_qpi) begin
                                r_is_rd <= (w_cmd == CMD_READ);
                                r_state <= ST_QPI_ADDR;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign mem_sio   = r_oe ? r_sio_out : 4'bzzzz;
    assign qpi_mode  = r_qpi;
    assign wr_strobe = r_wr_stb;
    assign rd_strobe = r_rd_stb;

`ifdef PSRAM_QSPI_RESPONDER_PROTOCOL_CHECK_EN
    logic w_cmd_known;
    logic w_err_evt;
    logic r_proto_err;

    always_comb begin
        if (r_state == ST_SPI_CMD) begin
            w_cmd_known = (w_cmd == CMD_RSTEN) || (w_cmd == CMD_RST) ||
                          (w_cmd == CMD_SPI2QPI);
        end else begin
            w_cmd_known = (w_cmd == CMD_RSTEN) || (w_cmd == CMD_RST) ||
                          (w_cmd == CMD_QPI2SPI) || (w_cmd == CMD_READ) ||
                          (w_cmd == CMD_WRITE);
        end
        w_err_evt = 1'b0;
        if (mem_ce) begin
            // Truncated command/address, or odd nibble count on write
            if ((r_state == ST_SPI_CMD) || (r_state == ST_QPI_CMD) ||
                (r_state == ST_QPI_ADDR))
                w_err_evt = 1'b1;
            if ((r_state == ST_WR_DATA) && r_half)
                w_err_evt = 1'b1;
        end else if (w_cmd_done) begin
            if (!w_cmd_known || ((w_cmd == CMD_RST) && !r_armed))
                w_err_evt = 1'b1;
        end
    end

    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) r_proto_err <= 1'b0;
        else        r_proto_err <= r_proto_err | w_err_evt;
    end

    assign proto_err = r_proto_err;
`else
    assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_psram_qspi_responder.sv
//-----------------------------------------------------------------------------
// tb_psram_qspi_responder
// Directed bench acting as the PSRAM controller: drives mem_ce/mem_sio on
// negedge and samples the responder 1 ns after each posedge. The quad bus has
// pull-ups, so a released bus reads 4'hF.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_psram_qspi_responder;

    localparam int DATA_K = 14;   // 8 + default READ_WAIT

`ifdef PSRAM_QSPI_RESPONDER_PROTOCOL_CHECK_EN
    localparam logic PERR_EN = 1'b1;
`else
    localparam logic PERR_EN = 1'b0;
`endif

    logic       mem_clk = 1'b0;
    logic       rst_n;
    logic       tb_ce;
    logic       tb_oe;
    logic [3:0] tb_sio;
    wire  [3:0] mem_sio;
    logic       qpi_mode, wr_strobe, rd_strobe, proto_err;

    int checks   = 0;
    int failures = 0;
    int wr_cnt   = 0;
    int rd_cnt   = 0;
    int snap;

    logic [3:0] tx_nib [64];
    logic [3:0] rx_nib [64];

    pullup p0 (mem_sio[0]);
    pullup p1 (mem_sio[1]);
    pullup p2 (mem_sio[2]);
    pullup p3 (mem_sio[3]);

    assign mem_sio = tb_oe ? tb_sio : 4'bzzzz;

    always #5 mem_clk = ~mem_clk;

    always @(posedge mem_clk) begin
        if (wr_strobe) wr_cnt <= wr_cnt + 1;
        if (rd_strobe) rd_cnt <= rd_cnt + 1;
    end

    psram_qspi_responder dut (
        .mem_clk   (mem_clk),
        .rst_n     (rst_n),
        .mem_ce    (tb_ce),
        .mem_sio   (mem_sio),
        .qpi_mode  (qpi_mode),
        .wr_strobe (wr_strobe),
        .rd_strobe (rd_strobe),
        .proto_err (proto_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive n_out nibbles, keep CE low for total posedges, capture the bus
    task automatic run_xfer(input int n_out, input int total, input bit end_ce);
        for (int k = 0; k < total; k++) begin
            @(negedge mem_clk);
            tb_ce = 1'b0;
            if (k < n_out) begin
                tb_oe  = 1'b1;
                tb_sio = tx_nib[k];
            end else begin
                tb_oe  = 1'b0;
            end
            @(posedge mem_clk);
            #1;
            rx_nib[k] = mem_sio;
        end
        if (end_ce) begin
            @(negedge mem_clk);
            tb_ce = 1'b1;
            tb_oe = 1'b0;
            @(posedge mem_clk);
            #1;
        end
    endtask

    task automatic fill_spi(input logic [7:0] b);
        for (int i = 0; i < 8; i++) tx_nib[i] = {3'b000, b[7-i]};
    endtask

    task automatic fill_qpi(input logic [7:0] cmd, input logic [23:0] a);
        tx_nib[0] = cmd[7:4];
        tx_nib[1] = cmd[3:0];
        for (int i = 0; i < 6; i++) tx_nib[2+i] = a[23-4*i -: 4];
    endtask

    task automatic put_byte(input int idx, input logic [7:0] b);
        tx_nib[idx]   = b[7:4];
        tx_nib[idx+1] = b[3:0];
    endtask

    task automatic spi_cmd(input logic [7:0] b);
        fill_spi(b);
        run_xfer(8, 8, 1'b1);
    endtask

    task automatic qpi_cmd(input logic [7:0] b);
        fill_qpi(b, 24'h0);
        run_xfer(2, 2, 1'b1);
    endtask

    // Bytes packed MSB-first in exp_bytes
    task automatic check_rd(input string tag, input logic [31:0] exp_bytes, input int nb);
        int nz;
        nz = 0;
        for (int k = 8; k < DATA_K; k++) if (rx_nib[k] !== 4'hF) nz++;
        chk({tag, "_turnaround"}, nz, 0);
        for (int j = 0; j < nb; j++) begin
            chk({tag, "_hi"}, {28'h0, rx_nib[DATA_K+2*j]},   {28'h0, exp_bytes[31-8*j -: 4]});
            chk({tag, "_lo"}, {28'h0, rx_nib[DATA_K+2*j+1]}, {28'h0, exp_bytes[27-8*j -: 4]});
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        tb_ce  = 1'b1;
        tb_oe  = 1'b0;
        tb_sio = 4'h0;
        repeat (3) @(posedge mem_clk);
        #1;
        chk("rst_qpi",  {31'h0, qpi_mode},  0);
        chk("rst_perr", {31'h0, proto_err}, 0);
        chk("rst_wstb", {31'h0, wr_strobe}, 0);
        chk("rst_rstb", {31'h0, rd_strobe}, 0);
        chk("rst_sio",  {28'h0, mem_sio},   32'hF);
        @(negedge mem_clk);
        rst_n = 1'b1;
        @(posedge mem_clk);
        #1;

        // SPI init sequence
        spi_cmd(8'h66);
        chk("spi66_qpi", {31'h0, qpi_mode}, 0);
        spi_cmd(8'h99);
        chk("spi99_qpi", {31'h0, qpi_mode}, 0);
        spi_cmd(8'h35);
        chk("spi35_qpi",  {31'h0, qpi_mode},  1);
        chk("init_perr",  {31'h0, proto_err}, 0);

        // Write AB CD at 010h, read back
        fill_qpi(8'h38, 24'h000010);
        put_byte(8, 8'hAB);
        put_byte(10, 8'hCD);
        snap = wr_cnt;
        run_xfer(12, 12, 1'b1);
        chk("wr10_strobes", wr_cnt - snap, 2);
        fill_qpi(8'hEB, 24'h000010);
        snap = rd_cnt;
        run_xfer(8, DATA_K + 4, 1'b1);
        check_rd("rd10", 32'hABCD_0000, 2);
        chk("rd10_strobes", rd_cnt - snap, 3);
        chk("rd10_release", {28'h0, mem_sio}, 32'hF);

        // Page wrap
        fill_qpi(8'h38, 24'h0003FF);
        put_byte(8, 8'h11);
        put_byte(10, 8'h22);
        put_byte(12, 8'h33);
        put_byte(14, 8'h44);
        run_xfer(16, 16, 1'b1);
        fill_qpi(8'hEB, 24'h0003FF);
        run_xfer(8, DATA_K + 8, 1'b1);
        check_rd("rd3ff", 32'h1122_3344, 4);
        fill_qpi(8'hEB, 24'h000000);
        run_xfer(8, DATA_K + 4, 1'b1);
        check_rd("rd000", 32'h2233_0000, 2);
        chk("wrap_perr", {31'h0, proto_err}, 0);

        // Odd nibble write: only 56h commits, 021h keeps EEh
        fill_qpi(8'h38, 24'h000020);
        put_byte(8, 8'h00);
        put_byte(10, 8'hEE);
        run_xfer(12, 12, 1'b1);
        fill_qpi(8'h38, 24'h000020);
        tx_nib[8]  = 4'h5;
        tx_nib[9]  = 4'h6;
        tx_nib[10] = 4'h7;
        snap = wr_cnt;
        run_xfer(11, 11, 1'b1);
        chk("odd_strobes", wr_cnt - snap, 1);
        chk("odd_perr", {31'h0, proto_err}, {31'h0, PERR_EN});
        fill_qpi(8'hEB, 24'h000020);
        run_xfer(8, DATA_K + 4, 1'b1);
        check_rd("rd020", 32'h56EE_0000, 2);

        // Reset-enable handling and mode exits
        qpi_cmd(8'h99);
        chk("q99_noarm_qpi", {31'h0, qpi_mode}, 1);
        qpi_cmd(8'h66);
        qpi_cmd(8'h99);
        chk("q66_99_qpi", {31'h0, qpi_mode}, 0);
        spi_cmd(8'h35);
        chk("spi35b_qpi", {31'h0, qpi_mode}, 1);
        qpi_cmd(8'hF5);
        chk("qf5_qpi", {31'h0, qpi_mode}, 0);
        spi_cmd(8'h99);
        chk("s99_noarm_qpi", {31'h0, qpi_mode}, 0);
        spi_cmd(8'h66);
        spi_cmd(8'h35);
        qpi_cmd(8'h99);
        chk("arm_cleared_qpi", {31'h0, qpi_mode}, 1);

        // Reset during read data
        fill_qpi(8'hEB, 24'h000010);
        run_xfer(8, DATA_K + 3, 1'b0);
        chk("pre_rst_sio", {28'h0, rx_nib[DATA_K+2]}, 32'hC);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_sio",  {28'h0, mem_sio},   32'hF);
        chk("midrst_qpi",  {31'h0, qpi_mode},  0);
        chk("midrst_perr", {31'h0, proto_err}, 0);
        @(negedge mem_clk);
        tb_ce = 1'b1;
        rst_n = 1'b1;
        @(posedge mem_clk);
        #1;
        spi_cmd(8'h35);
        chk("recover_qpi", {31'h0, qpi_mode}, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
